// File: rtl/chacha_keystream_engine.sv
// ChaCha block-function keystream engine: accepts a 512-bit initial state plus a block
// count and emits consecutive keystream blocks, one double round per clock.
module chacha_keystream_engine #(
   parameter int ROUND_COUNT = 20,
   parameter int LEN_W       = 16
) (
   input  logic             aclk,
   input  logic             aresetn,
   input  logic             srst,
   input  logic             i_tvalid,
   output logic             i_tready,
   input  logic [511:0]     i_tdata,
   input  logic [LEN_W-1:0] i_tlen,
   output logic             o_tvalid,
   input  logic             o_tready,
   output logic [511:0]     o_tdata,
   output logic [31:0]      o_tuser,
   output logic             o_tlast,
   output logic             o_wrap_err,
   output logic [1:0]       dbg_state
);

   // Both ports are valid/ready: a transfer happens on a rising edge where valid and
   // ready are both 1; o_tvalid never drops and o_tdata/o_tuser/o_tlast never change
   // until that transfer, and i_tready depends only on the registered state.
   localparam int HALF = ROUND_COUNT / 2;
   localparam int RC_W = $clog2(HALF + 1);
   localparam logic [RC_W-1:0] LAST_RC = RC_W'(HALF - 1);

   typedef enum logic [1:0] {IDLE, ROUND, FINAL, OUT} state_t;

   state_t             state_q, state_d;
   logic [511:0]       init_q, work_q;
   logic [LEN_W-1:0]   remaining_q;
   logic [RC_W-1:0]    rc_q;
   logic [31:0]        ctr_next;

   function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
      return (v << n) | (v >> (32 - n));
   endfunction

   function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
      logic [31:0] a, b, c, d;
      a = a_i; b = b_i; c = c_i; d = d_i;
      a = a + b; d = rotl(d ^ a, 16);
      c = c + d; b = rotl(b ^ c, 12);
      a = a + b; d = rotl(d ^ a, 8);
      c = c + d; b = rotl(b ^ c, 7);
      return {a, b, c, d};
   endfunction

   function automatic logic [511:0] double_round(input logic [511:0] s);
      logic [31:0]  x [16];
      logic [511:0] o;
      for (int i = 0; i < 16; i++) x[i] = s[32*i +: 32];
      for (int i = 0; i < 4; i++)
         {x[i], x[i+4], x[i+8], x[i+12]} = qr(x[i], x[i+4], x[i+8], x[i+12]);
      // Diagonal i starts at word i and steps one column right per row.
      for (int i = 0; i < 4; i++)
         {x[i], x[4+(i+1)%4], x[8+(i+2)%4], x[12+(i+3)%4]} =
            qr(x[i], x[4+(i+1)%4], x[8+(i+2)%4], x[12+(i+3)%4]);
      for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i];
      return o;
   endfunction

   function automatic logic [511:0] add_words(input logic [511:0] a, input logic [511:0] b);
      logic [511:0] o;
      for (int i = 0; i < 16; i++) o[32*i +: 32] = a[32*i +: 32] + b[32*i +: 32];
      return o;
   endfunction

   assign ctr_next  = init_q[415:384] + 32'd1;
   assign i_tready  = (state_q == IDLE);
   assign o_tvalid  = (state_q == OUT);
   assign dbg_state = state_q;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)  state_q <= IDLE;
      else if (srst) state_q <= IDLE;
      else           state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (i_tvalid) state_d = ROUND;
         ROUND:   if (rc_q == LAST_RC) state_d = FINAL;
         FINAL:   state_d = OUT;
         OUT:     if (o_tready) state_d = (remaining_q == '0) ? IDLE : ROUND;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn || srst) begin
         init_q      <= '0;
         work_q      <= '0;
         remaining_q <= '0;
         rc_q        <= '0;
         o_tdata     <= '0;
         o_tuser     <= '0;
         o_tlast     <= 1'b0;
         o_wrap_err  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (i_tvalid) begin
               init_q      <= i_tdata;
               work_q      <= i_tdata;
               remaining_q <= i_tlen;
               rc_q        <= '0;
               o_wrap_err  <= 1'b0;
            end
            ROUND: begin
               work_q <= double_round(work_q);
               rc_q   <= rc_q + RC_W'(1);
            end
            FINAL: begin
               o_tdata <= add_words(work_q, init_q);
               o_tuser <= init_q[415:384];
               o_tlast <= (remaining_q == '0);
            end
            OUT: if (o_tready && remaining_q != '0) begin
               // Next block restarts from the original state with the counter bumped.
               remaining_q       <= remaining_q - LEN_W'(1);
               init_q[415:384]   <= ctr_next;
               work_q            <= {init_q[511:416], ctr_next, init_q[383:0]};
               rc_q              <= '0;
               if (init_q[415:384] == 32'hFFFF_FFFF) o_wrap_err <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_chacha_keystream_engine.sv
// Bench for chacha_keystream_engine: vector table plus scoreboard against an
// independent per-round ChaCha model, with reset/stall/wrap sequences.
module tb_chacha_keystream_engine;
   localparam int LEN_W = 16;
   localparam int RC    = 20;
   localparam int EXP_W = 512 + 32 + 1 + 1;

   logic             aclk = 1'b0;
   logic             aresetn = 1'b0;
   logic             srst = 1'b0;
   logic             i_tvalid = 1'b0;
   logic             o_tready = 1'b0;
   logic [511:0]     i_tdata = '0;
   logic [LEN_W-1:0] i_tlen = '0;

   logic         i_tready, o_tvalid, o_tlast, o_wrap_err;
   logic [511:0] o_tdata;
   logic [31:0]  o_tuser;
   logic [1:0]   dbg_state;

   logic         r8_ready, r8_valid, r8_last, r8_wrap;
   logic [511:0] r8_data;
   logic [31:0]  r8_user;
   logic [1:0]   r8_state;
   logic         r12_ready, r12_valid, r12_last, r12_wrap;
   logic [511:0] r12_data;
   logic [31:0]  r12_user;
   logic [1:0]   r12_state;

   chacha_keystream_engine #(.ROUND_COUNT(RC), .LEN_W(LEN_W)) dut (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .i_tdata(i_tdata), .i_tlen(i_tlen), .o_tvalid(o_tvalid), .o_tready(o_tready),
      .o_tdata(o_tdata), .o_tuser(o_tuser), .o_tlast(o_tlast), .o_wrap_err(o_wrap_err),
      .dbg_state(dbg_state));

   chacha_keystream_engine #(.ROUND_COUNT(8), .LEN_W(LEN_W)) dut8 (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .i_tvalid(i_tvalid), .i_tready(r8_ready),
      .i_tdata(i_tdata), .i_tlen(i_tlen), .o_tvalid(r8_valid), .o_tready(o_tready),
      .o_tdata(r8_data), .o_tuser(r8_user), .o_tlast(r8_last), .o_wrap_err(r8_wrap),
      .dbg_state(r8_state));

   chacha_keystream_engine #(.ROUND_COUNT(12), .LEN_W(LEN_W)) dut12 (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .i_tvalid(i_tvalid), .i_tready(r12_ready),
      .i_tdata(i_tdata), .i_tlen(i_tlen), .o_tvalid(r12_valid), .o_tready(o_tready),
      .o_tdata(r12_data), .o_tuser(r12_user), .o_tlast(r12_last), .o_wrap_err(r12_wrap),
      .dbg_state(r12_state));

   always #5 aclk = ~aclk;

   typedef struct {
      logic [511:0]     st;
      logic [LEN_W-1:0] len;
      int               stall;
      bit               kat;
      logic [31:0]      w0;
      logic [31:0]      w15;
      bit               exp_wrap;
   } vec_t;

   vec_t             vecs[5];
   logic [EXP_W-1:0] exp_q[$];
   int               tests = 0;
   int               fails = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] ref_block(input logic [511:0] st, input int rounds);
      logic [31:0]  x[16];
      logic [511:0] o;
      int           qi[32];
      int           k, a, b, c, d;
      qi = '{0,4,8,12, 1,5,9,13, 2,6,10,14, 3,7,11,15,
             0,5,10,15, 1,6,11,12, 2,7,8,13, 3,4,9,14};
      for (int i = 0; i < 16; i++) x[i] = st[32*i +: 32];
      for (int r = 0; r < rounds; r++) begin
         for (int q = 0; q < 4; q++) begin
            k = (r % 2) * 16 + q * 4;
            a = qi[k]; b = qi[k+1]; c = qi[k+2]; d = qi[k+3];
            x[a] = x[a] + x[b]; x[d] = x[d] ^ x[a]; x[d] = {x[d][15:0], x[d][31:16]};
            x[c] = x[c] + x[d]; x[b] = x[b] ^ x[c]; x[b] = {x[b][19:0], x[b][31:20]};
            x[a] = x[a] + x[b]; x[d] = x[d] ^ x[a]; x[d] = {x[d][23:0], x[d][31:24]};
            x[c] = x[c] + x[d]; x[b] = x[b] ^ x[c]; x[b] = {x[b][24:0], x[b][31:25]};
         end
      end
      for (int i = 0; i < 16; i++) o[32*i +: 32] = x[i] + st[32*i +: 32];
      return o;
   endfunction

   function automatic logic [511:0] rfc_state(input logic [31:0] ctr);
      logic [31:0]  w[16];
      logic [511:0] s;
      w = '{32'h61707865, 32'h3320646e, 32'h79622d32, 32'h6b206574,
            32'h03020100, 32'h07060504, 32'h0b0a0908, 32'h0f0e0d0c,
            32'h13121110, 32'h17161514, 32'h1b1a1918, 32'h1f1e1d1c,
            32'h00000001, 32'h09000000, 32'h4a000000, 32'h00000000};
      w[12] = ctr;
      for (int i = 0; i < 16; i++) s[32*i +: 32] = w[i];
      return s;
   endfunction

   function automatic logic [511:0] rand_state();
      logic [511:0] s;
      for (int i = 0; i < 16; i++) s[32*i +: 32] = $urandom;
      return s;
   endfunction

   task automatic accept_job(input logic [511:0] st, input logic [LEN_W-1:0] len);
      int          w;
      logic [31:0] ctr;
      bit          wr;
      w = 0;
      while (!i_tready && w < 50) begin
         @(posedge aclk); #1; w++;
      end
      chk("accept_ready", i_tready, 1);
      i_tvalid = 1'b1; i_tdata = st; i_tlen = len;
      @(posedge aclk); #1;
      i_tvalid = 1'b0; i_tdata = rand_state(); i_tlen = LEN_W'($urandom);
      ctr = st[415:384]; wr = 1'b0;
      for (int b = 0; b <= int'(len); b++) begin
         logic [511:0] s;
         s = st; s[415:384] = ctr;
         exp_q.push_back({ref_block(s, RC), ctr, (b == int'(len)), wr});
         if (ctr == 32'hFFFF_FFFF) wr = 1'b1;
         ctr = ctr + 32'd1;
      end
      chk("ready_low_after_accept", i_tready, 0);
      chk("wrap_clear_on_accept", o_wrap_err, 0);
   endtask

   task automatic wait_block();
      int lat;
      lat = 0;
      while (!o_tvalid && lat < 200) begin
         @(posedge aclk); #1; lat++;
      end
      chk("latency", lat, RC / 2 + 1);
   endtask

   task automatic take_block(input int stall, output logic [511:0] data);
      logic [511:0]     snap_d;
      logic [33:0]      snap_c;
      logic [EXP_W-1:0] e;
      wait_block();
      snap_d = o_tdata;
      snap_c = {o_tvalid, o_tlast, o_tuser};
      for (int s = 0; s < stall; s++) begin
         o_tready = 1'b0;
         @(posedge aclk); #1;
         chk("stall_data", o_tdata, snap_d);
         chk("stall_ctl", {o_tvalid, o_tlast, o_tuser}, snap_c);
      end
      data = o_tdata;
      if (exp_q.size() == 0) begin
         chk("scoreboard_nonempty", 0, 1);
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
      chk("block_data", o_tdata, e[EXP_W-1 -: 512]);
      chk("block_user", o_tuser, e[33:2]);
      chk("block_last", o_tlast, e[1]);
      chk("block_wrap", o_wrap_err, e[0]);
      o_tready = 1'b1;
      @(posedge aclk); #1;
      o_tready = 1'b0;
      if (e[1]) chk("b2b_ready", i_tready, 1);
   endtask

   task automatic run_vec(input vec_t v);
      logic [511:0] d;
      accept_job(v.st, v.len);
      for (int b = 0; b <= int'(v.len); b++) begin
         take_block(v.stall, d);
         if (b == 0 && v.kat) begin
            chk("kat_word0", d[31:0], v.w0);
            chk("kat_word15", d[511:480], v.w15);
         end
      end
      chk("wrap_after_job", o_wrap_err, v.exp_wrap);
      chk("scoreboard_drained", exp_q.size(), 0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      logic [511:0] st, d;
      int           l8, l12, l20;
      bit           seen;

      vecs[0] = '{st: rfc_state(32'd1), len: 0, stall: 0, kat: 1,
                  w0: 32'he4e7f110, w15: 32'h4e3c50a2, exp_wrap: 0};
      vecs[1] = '{st: rfc_state(32'd1), len: 2, stall: 5, kat: 1,
                  w0: 32'he4e7f110, w15: 32'h4e3c50a2, exp_wrap: 0};
      vecs[2] = '{st: rfc_state(32'hFFFF_FFFE), len: 3, stall: 1, kat: 0,
                  w0: 0, w15: 0, exp_wrap: 1};
      st = rand_state(); st[415:384] = $urandom_range(0, 1000);
      vecs[3] = '{st: st, len: 1, stall: $urandom_range(0, 3), kat: 0, w0: 0, w15: 0, exp_wrap: 0};
      st = rand_state(); st[415:384] = $urandom_range(0, 1000);
      vecs[4] = '{st: st, len: 0, stall: 2, kat: 0, w0: 0, w15: 0, exp_wrap: 0};

      // clock/reset
      repeat (2) @(posedge aclk);
      #1;
      chk("reset_outputs", {o_tvalid, o_tlast, o_wrap_err, o_tuser}, 0);
      chk("reset_data", o_tdata, 0);
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("ready_after_reset", i_tready, 1);
      chk("state_after_reset", dbg_state, 0);

      for (int i = 0; i < 5; i++) run_vec(vecs[i]);

      // asynchronous reset mid-ROUND of block 2
      accept_job(rfc_state(32'd1), 2);
      take_block(0, d);
      repeat (3) @(posedge aclk);
      #1;
      aresetn = 1'b0;
      #1;
      chk("arst_ctl", {o_tvalid, o_tlast, o_wrap_err, o_tuser}, 0);
      chk("arst_data", o_tdata, 0);
      chk("arst_state", dbg_state, 0);
      exp_q.delete();
      #2;
      aresetn = 1'b1;
      @(posedge aclk); #1;
      chk("arst_ready_after_release", i_tready, 1);
      run_vec(vecs[0]);

      // synchronous clear while stalled in OUT
      accept_job(rand_state(), 1);
      wait_block();
      o_tready = 1'b0;
      srst = 1'b1;
      @(posedge aclk); #1;
      srst = 1'b0;
      chk("srst_valid", o_tvalid, 0);
      chk("srst_data", o_tdata, 0);
      chk("srst_ready", i_tready, 1);
      exp_q.delete();
      o_tready = 1'b1;
      seen = 1'b0;
      repeat (30) begin
         @(posedge aclk); #1;
         if (o_tvalid) seen = 1'b1;
      end
      o_tready = 1'b0;
      chk("srst_no_more_blocks", seen, 0);

      // 8/12/20-round builds against the model
      srst = 1'b1;
      @(posedge aclk); #1;
      srst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         st = rand_state();
         chk("multi_ready", {r8_ready, r12_ready, i_tready}, 3'b111);
         i_tvalid = 1'b1; i_tdata = st; i_tlen = '0;
         @(posedge aclk); #1;
         i_tvalid = 1'b0;
         l8 = 0; l12 = 0; l20 = 0;
         for (int e = 1; e <= 30; e++) begin
            @(posedge aclk); #1;
            if (r8_valid && l8 == 0) l8 = e;
            if (r12_valid && l12 == 0) l12 = e;
            if (o_tvalid && l20 == 0) l20 = e;
            if (l8 != 0 && l12 != 0 && l20 != 0) break;
         end
         chk("lat_r8", l8, 5);
         chk("lat_r12", l12, 7);
         chk("lat_r20", l20, 11);
         chk("data_r8", r8_data, ref_block(st, 8));
         chk("data_r12", r12_data, ref_block(st, 12));
         chk("data_r20", o_tdata, ref_block(st, 20));
         o_tready = 1'b1;
         @(posedge aclk); #1;
         o_tready = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/chacha_keystream_engine.md
CHACHA_KEYSTREAM_ENGINE -- requirements
Module: chacha_keystream_engine

Interface
REQ-001 Parameter ROUND_COUNT, default 20: total ChaCha rounds; SHALL be even, legal values 8, 12, 20.
REQ-002 Parameter LEN_W, default 16: width of the block-count field.
REQ-003 aclk  in  1  single clock; all logic rising-edge.
REQ-004 aresetn  in  1  asynchronous active-low reset.
REQ-005 srst  in  1  synchronous active-high clear, same effect as aresetn.
REQ-006 i_tvalid  in  1  job request.
REQ-007 i_tready  out  1  engine can accept a job.
REQ-008 i_tdata  in  512  initial state; word k = bits [32k+31:32k]; words 0-3 constants, 4-11 key, 12 block counter, 13-15 nonce.
REQ-009 i_tlen  in  LEN_W  number of blocks minus one; sampled with i_tdata.
REQ-010 o_tvalid  out  1  keystream block valid.
REQ-011 o_tready  in  1  downstream accepts block.
REQ-012 o_tdata  out  512  keystream block, same word layout as i_tdata.
REQ-013 o_tuser  out  32  block-counter value used for o_tdata.
REQ-014 o_tlast  out  1  last block of the job.
REQ-015 o_wrap_err  out  1  sticky flag: block counter wrapped within the job.

Function
REQ-016 FSM states: IDLE, ROUND, FINAL, OUT; i_tready SHALL be 1 only in IDLE.
REQ-017 Job accept (i_tvalid && i_tready at an edge): initial register <= i_tdata, working register <= i_tdata, remaining <= i_tlen, round counter <= 0, o_wrap_err <= 0, go ROUND.
REQ-018 ROUND: each edge applies one double round (4 column QRs (0,4,8,12)(1,5,9,13)(2,6,10,14)(3,7,11,15), then 4 diagonal QRs (0,5,10,15)(1,6,11,12)(2,7,8,13)(3,4,9,14)) combinationally to working; after ROUND_COUNT/2 edges go FINAL.
REQ-019 QR per RFC 8439: a+=b; d^=a; d<<<=16; c+=d; b^=c; b<<<=12; a+=b; d^=a; d<<<=8; c+=d; b^=c; b<<<=7; all adds modulo 2^32.
REQ-020 FINAL: one edge; output register <= word-wise (working + initial) mod 2^32; o_tuser <= initial word 12; o_tlast <= (remaining==0); go OUT.
REQ-021 Latency: o_tvalid SHALL rise ROUND_COUNT/2+1 edges after the accept edge (11 for ChaCha20).
REQ-022 OUT: o_tvalid=1; o_tdata/o_tuser/o_tlast SHALL hold stable until o_tvalid && o_tready.
REQ-023 OUT handshake with remaining==0: go IDLE, o_tvalid <= 0.
REQ-024 OUT handshake with remaining>0: remaining--, initial word 12 <= word 12 + 1 mod 2^32, working <= updated initial, go ROUND; next o_tvalid rises ROUND_COUNT/2+1 edges later.
REQ-025 Counter wrap: if the REQ-024 increment takes word 12 from 0xFFFFFFFF to 0, o_wrap_err SHALL set and remain 1 until the next job accept; generation continues.
REQ-026 o_tready is ignored outside OUT; i_tvalid and i_tdata are ignored outside IDLE.
REQ-027 Back-to-back: i_tready may rise the cycle after the final OUT handshake; no combinational path from o_tready to i_tready.

Reset
REQ-028 On aresetn low (asynchronous) or srst high at an edge: FSM=IDLE, all registers 0, o_tvalid=0, o_tlast=0, o_wrap_err=0, o_tdata=0, o_tuser=0; an in-flight job is discarded.
REQ-029 After reset release, i_tready SHALL be 1 on the first cycle.

Verification
REQ-030 RFC 8439 sec 2.3.2 state (key 00..1f, nonce 00000009 0000004a 00000000, counter 1), i_tlen=0, ROUND_COUNT=20 -> o_tvalid 11 edges after accept; o_tdata word0=0xe4e7f110, word15=0x4e3c50a2; o_tuser=1; o_tlast=1.
REQ-031 Same key, counter 1, i_tlen=2, o_tready held 0 for 5 cycles at each OUT -> three blocks with o_tuser 1,2,3, data stable while stalled, o_tlast only on third.
REQ-032 Word 12 = 0xFFFFFFFE, i_tlen=3 -> o_tuser FFFFFFFE, FFFFFFFF, 0, 1; o_wrap_err rises after second handshake, stays 1; clears on next accept.
REQ-033 aresetn pulsed low mid-ROUND of block 2 -> all outputs 0 immediately, i_tready=1 after release, new job produces correct first block.
REQ-034 srst asserted for one edge during OUT with o_tready=0 -> o_tvalid=0 next cycle, no further blocks.
REQ-035 ROUND_COUNT=8 and 12 builds, random states vs software model -> o_tdata matches, latency 5 and 7 edges respectively.
